// File: rtl/uart_core.sv
// uart_core: single-clock full-duplex UART with a shared 16x oversampling
// baud generator, framing-error and overrun detection.
// Optional feature macro: UART_PARITY_EN adds a parity bit (PARITY_ODD
// selects odd parity) and the rx_parity_err output.
//
// Handshake: ld_tx_data is honoured only while tx_empty=1 (otherwise it is
// dropped); uld_rx_data marks the current rx_data as consumed.
module uart_core #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
`ifdef UART_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_tx_data,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_enable,
  output logic                 tx_out,
  output logic                 tx_empty,
  input  logic                 uld_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  output logic                 rx_empty,
  output logic                 rx_frame_err,
`ifdef UART_PARITY_EN
  output logic                 rx_parity_err,
`endif
  output logic                 rx_overrun
);

  localparam int DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef UART_PARITY_EN
  localparam logic PO = (PARITY_ODD != 0);
`endif

  // ---------------- baud generator ----------------
  logic [CW-1:0] baud_q, baud_d;
  logic          tick;

  // Free-running divider; tick is the one-cycle 16x oversampling strobe.
  always_comb begin
    tick   = (baud_q == CW'(DIV - 1));
    baud_d = tick ? '0 : baud_q + 1'b1;
  end

  // Baud counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) baud_q <= '0;
    else       baud_q <= baud_d;
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [3:0]           tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_BITS-1:0] tx_hold_q, tx_hold_d;
  logic                 tx_empty_q, tx_empty_d;
  logic                 tx_out_q, tx_out_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  // TX holding register, frame sequencing and registered line value.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    tx_out_d   = 1'b1;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (ld_tx_data && tx_empty_q) begin
      tx_hold_d  = tx_data;
      tx_empty_d = 1'b0;
    end
    if (tick) begin
      case (tx_state_q)
        TX_IDLE: begin
          // Holding register moves to the shifter and frees up at once so
          // the next byte can be loaded during this frame.
          if (!tx_empty_q && tx_enable) begin
            tx_state_d = TX_START;
            tx_shift_d = tx_hold_q;
            tx_empty_d = 1'b1;
            tx_cnt_d   = 4'd0;
`ifdef UART_PARITY_EN
            tx_par_d   = (^tx_hold_q) ^ PO;
`endif
          end
        end
        TX_START: begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_state_d = TX_DATA;
            tx_bit_d   = 4'd0;
          end
        end
        TX_DATA: begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_shift_d = tx_shift_q >> 1;
            if (tx_bit_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx_state_d = TX_PARITY;
`else
              tx_state_d = TX_STOP;
`endif
              tx_bit_d = 4'd0;
            end else begin
              tx_bit_d = tx_bit_q + 4'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_state_d = TX_STOP;
            tx_bit_d   = 4'd0;
          end
        end
`endif
        TX_STOP: begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            if (tx_bit_q == 4'(STOP_BITS - 1)) tx_state_d = TX_IDLE;
            else                               tx_bit_d   = tx_bit_q + 4'd1;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
    case (tx_state_d)
      TX_START:  tx_out_d = 1'b0;
      TX_DATA:   tx_out_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_out_d = tx_par_d;
`endif
      default:   tx_out_d = 1'b1;
    endcase
  end

  // TX registers; reset forces the line high asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 4'd0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      tx_empty_q <= 1'b1;
      tx_out_q   <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_empty_q <= tx_empty_d;
      tx_out_q   <= tx_out_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_empty = tx_empty_q;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_s1_q, rx_s2_q;
  logic [3:0]           rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_empty_q, rx_empty_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;
`ifdef UART_PARITY_EN
  logic                 rx_pbit_q, rx_pbit_d;
  logic                 rx_perr_q, rx_perr_d;
`endif

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_in;
      rx_s2_q <= rx_s1_q;
    end
  end

  // RX sequencing: mid-bit sampling at count 7, completion at the stop bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_empty_d = rx_empty_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;
`ifdef UART_PARITY_EN
    rx_pbit_d  = rx_pbit_q;
    rx_perr_d  = rx_perr_q;
`endif
    if (uld_rx_data) begin
      rx_empty_d = 1'b1;
      rx_ovr_d   = 1'b0;
    end
    if (!rx_enable) begin
      rx_state_d = RX_IDLE;
    end else if (tick) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s2_q) begin
            rx_state_d = RX_START;
            rx_cnt_d   = 4'd0;
          end
        end
        RX_START: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd7 && rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else if (rx_cnt_q == 4'd15) begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 4'd0;
          end
        end
        RX_DATA: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd7) rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_cnt_q == 4'd15) begin
            if (rx_bit_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              rx_state_d = RX_PARITY;
`else
              rx_state_d = RX_STOP;
`endif
            end else begin
              rx_bit_d = rx_bit_q + 4'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd7)  rx_pbit_d  = rx_s2_q;
          if (rx_cnt_q == 4'd15) rx_state_d = RX_STOP;
        end
`endif
        RX_STOP: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          // Leaving at mid stop bit leaves half a bit to catch the next start.
          if (rx_cnt_q == 4'd7) begin
            rx_state_d = RX_IDLE;
            rx_ferr_d  = ~rx_s2_q;
            rx_data_d  = rx_shift_q;
            rx_empty_d = 1'b0;
            // A coincident unload consumes the old byte, so no overrun.
            rx_ovr_d   = uld_rx_data ? 1'b0 : (!rx_empty_q ? 1'b1 : rx_ovr_q);
`ifdef UART_PARITY_EN
            rx_perr_d  = rx_pbit_q ^ (^rx_shift_q) ^ PO;
`endif
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // RX registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 4'd0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_empty_q <= 1'b1;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_pbit_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_empty_q <= rx_empty_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
`ifdef UART_PARITY_EN
      rx_pbit_q  <= rx_pbit_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_empty     = rx_empty_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_overrun   = rx_ovr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_perr_q;
`endif

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed and randomized checks of uart_core with
// CLK_FREQ=1600000, BAUD=100000 (one bit = 16 clocks).
module tb_uart_core;

`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR;   // start + 8 data + [parity] + first stop

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ld_tx_data = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_enable = 1'b1;
  logic       tx_out;
  logic       tx_empty;
  logic       uld_rx_data = 1'b0;
  logic [7:0] rx_data;
  logic       rx_enable = 1'b1;
  logic       rx_in;
  logic       rx_empty;
  logic       rx_frame_err;
  logic       rx_overrun;
`ifdef UART_PARITY_EN
  logic       rx_parity_err;
`endif
  logic       loop_en = 1'b0;
  logic       rx_drv = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  assign rx_in = loop_en ? tx_out : rx_drv;

  uart_core #(.CLK_FREQ(1600000), .BAUD(100000)) dut (
    .clk(clk), .reset(reset),
    .ld_tx_data(ld_tx_data), .tx_data(tx_data), .tx_enable(tx_enable),
    .tx_out(tx_out), .tx_empty(tx_empty),
    .uld_rx_data(uld_rx_data), .rx_data(rx_data), .rx_enable(rx_enable),
    .rx_in(rx_in), .rx_empty(rx_empty), .rx_frame_err(rx_frame_err),
`ifdef UART_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_overrun(rx_overrun)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: serial line value of bit i of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int i, input logic flip_par);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (PAR == 1 && i == 9) return (^b) ^ flip_par;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_uld();
    uld_rx_data = 1'b1;
    step(1);
    uld_rx_data = 1'b0;
  endtask

  // driver: load one byte once the holding register is free
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!tx_empty && n < 400) begin step(1); n++; end
    check("send_wait_empty", tx_empty, 1);
    tx_data    = b;
    ld_tx_data = 1'b1;
    step(1);
    ld_tx_data = 1'b0;
  endtask

  task automatic wait_rx_full(input string tag);
    int n = 0;
    while (rx_empty && n < 400) begin step(1); n++; end
    check(tag, rx_empty, 0);
  endtask

  // monitor: find the start bit, then sample every bit at mid-bit
  task automatic check_tx_frame(input logic [7:0] b, input string tag);
    int n = 0;
    while (tx_out && n < 400) begin step(1); n++; end
    check({tag, "_start_seen"}, tx_out, 0);
    step(8);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s_bit%0d", tag, i), tx_out, frame_bit(b, i, 1'b0));
      step(16);
    end
  endtask

  // driver: serial frame on rx_drv; a low stop bit returns high after
  // 12 clocks so the tail is rejected as a glitch rather than a start
  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_low, input logic flip_par);
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1 && stop_low) begin
        rx_drv = 1'b0;
        step(12);
        rx_drv = 1'b1;
        step(4);
      end else begin
        rx_drv = frame_bit(b, i, flip_par);
        step(16);
      end
    end
    rx_drv = 1'b1;
    step(24);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] e;

    // reset values
    step(3);
    check("rst_tx_out", tx_out, 1);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", rx_frame_err, 0);
    check("rst_overrun", rx_overrun, 0);
    reset = 1'b0;
    step(4);

    // single TX frame A5
    send(8'hA5);
    check("a5_tx_empty_after_load", tx_empty, 0);
    step(1);
    check("a5_tx_out_low_at_start", tx_out, 0);
    check("a5_tx_empty_at_start", tx_empty, 1);
    check_tx_frame(8'hA5, "a5");
    step(20);

    // loopback back-to-back 3C, C3 with an ignored load in between
    loop_en = 1'b1;
    send(8'h3C);
    send(8'hC3);
    check("busy_tx_empty", tx_empty, 0);
    tx_data    = 8'hFF;
    ld_tx_data = 1'b1;
    step(1);
    ld_tx_data = 1'b0;
    wait_rx_full("lb1_wait");
    check("lb1_data", rx_data, 8'h3C);
    check("lb1_ferr", rx_frame_err, 0);
    check("lb1_ovr", rx_overrun, 0);
    pulse_uld();
    check("lb1_uld_empty", rx_empty, 1);
    wait_rx_full("lb2_wait");
    check("lb2_data", rx_data, 8'hC3);
    check("lb2_ferr", rx_frame_err, 0);
    check("lb2_ovr", rx_overrun, 0);
    pulse_uld();
    step(200);
    check("lb_ignored_load_no_byte", rx_empty, 1);

    // overrun: two frames without unload
    send(8'h11);
    send(8'h22);
    wait_rx_full("ovr_wait1");
    begin
      int n = 0;
      while (!rx_overrun && n < 400) begin step(1); n++; end
    end
    check("ovr_flag", rx_overrun, 1);
    check("ovr_data", rx_data, 8'h22);
    check("ovr_not_empty", rx_empty, 0);
    pulse_uld();
    check("ovr_cleared", rx_overrun, 0);
    check("ovr_uld_empty", rx_empty, 1);
    step(40);

    // glitch rejection on rx_in
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    step(20);
    rx_drv = 1'b0;
    step(5);
    rx_drv = 1'b1;
    step(60);
    check("glitch_rx_empty", rx_empty, 1);
    check("glitch_ferr", rx_frame_err, 0);

    // framing error on 55, then a clean frame clears the flag
    drive_rx_frame(8'h55, 1'b1, 1'b0);
    check("ferr_flag", rx_frame_err, 1);
    check("ferr_data", rx_data, 8'h55);
    check("ferr_not_empty", rx_empty, 0);
    pulse_uld();
    drive_rx_frame(8'hA3, 1'b0, 1'b0);
    check("clean_ferr", rx_frame_err, 0);
    check("clean_data", rx_data, 8'hA3);
    pulse_uld();

    // randomized loopback against the byte scoreboard
    loop_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send(b);
      wait_rx_full($sformatf("rnd%0d_wait", k));
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_data", k), rx_data, e);
      check($sformatf("rnd%0d_ferr", k), rx_frame_err, 0);
      pulse_uld();
      step($urandom_range(0, 40));
    end
    step(200);

    // reset in the middle of the data bits of an all-zero frame
    loop_en = 1'b0;
    send(8'h00);
    begin
      int n = 0;
      while (tx_out && n < 400) begin step(1); n++; end
    end
    step(16 + 40);
    check("rstmid_data_bit_low", tx_out, 0);
    reset = 1'b1;
    #1;
    check("rstmid_tx_out", tx_out, 1);
    check("rstmid_tx_empty", tx_empty, 1);
    step(3);
    reset = 1'b0;
    step(4);
    send(8'h0F);
    check_tx_frame(8'h0F, "post_rst");
    step(20);

`ifdef UART_PARITY_EN
    // parity: 07 carries an even-parity bit of 1; a flipped bit is flagged
    send(8'h07);
    check_tx_frame(8'h07, "par07");
    drive_rx_frame(8'h07, 1'b0, 1'b1);
    check("par_err_flag", rx_parity_err, 1);
    check("par_err_data", rx_data, 8'h07);
    pulse_uld();
    drive_rx_frame(8'h07, 1'b0, 1'b0);
    check("par_ok_flag", rx_parity_err, 0);
    pulse_uld();
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
